// File: rtl/vga_timgen_pkg.sv
// Shared types for the VGA/LCD timing generator: axis phase encoding and the
// per-axis timing configuration record.
package vga_timgen_pkg;

    localparam int unsigned TIM_W_DEF = 8;
    localparam int unsigned ACT_W_DEF = 12;

    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BP,
        PH_ACT,
        PH_FP
    } phase_e;

    // All fields are "length minus 1", so every phase lasts at least one unit.
    typedef struct packed {
        logic [TIM_W_DEF-1:0] sn;
        logic [TIM_W_DEF-1:0] bp;
        logic [TIM_W_DEF-1:0] fp;
        logic [ACT_W_DEF-1:0] vlen;
    } axis_cfg_t;

    function automatic phase_e next_phase(input phase_e ph);
        phase_e nxt;
        nxt = PH_SYNC;
        unique case (ph)
            PH_SYNC: nxt = PH_BP;
            PH_BP:   nxt = PH_ACT;
            PH_ACT:  nxt = PH_FP;
            PH_FP:   nxt = PH_SYNC;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: SYNC/BP/ACTIVE/FP phase FSM with its phase counter and the
// shadowed size fields. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_fsm
    import vga_timgen_pkg::*;
#(
    parameter int unsigned ACT_W = ACT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             adv_i,
    input  logic             load_i,
    input  axis_cfg_t        cfg_i,
    output phase_e           ph_o,
    output logic [ACT_W-1:0] cnt_o,
    output logic             last_o,
    output logic [ACT_W-1:0] coord_o
);

    phase_e           ph_q;
    logic [ACT_W-1:0] cnt_q;
    axis_cfg_t        shd_q;
    logic [ACT_W-1:0] len;

    always_comb begin
        len = '0;
        unique case (ph_q)
            PH_SYNC: len = ACT_W'(shd_q.sn);
            PH_BP:   len = ACT_W'(shd_q.bp);
            PH_ACT:  len = ACT_W'(shd_q.vlen);
            PH_FP:   len = ACT_W'(shd_q.fp);
        endcase
    end

    // en_i low parks the axis at the start of SYNC regardless of adv_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ph_q  <= PH_SYNC;
            cnt_q <= '0;
            shd_q <= '0;
        end else begin
            if (load_i) begin
                shd_q <= cfg_i;
            end
            if (!en_i) begin
                ph_q  <= PH_SYNC;
                cnt_q <= '0;
            end else if (adv_i) begin
                if (cnt_q == len) begin
                    cnt_q <= '0;
                    ph_q  <= next_phase(ph_q);
                end else begin
                    cnt_q <= cnt_q + ACT_W'(1);
                end
            end
        end
    end

    assign ph_o    = ph_q;
    assign cnt_o   = cnt_q;
    assign last_o  = (ph_q == PH_FP) && (cnt_q == ACT_W'(shd_q.fp));
    assign coord_o = (ph_q == PH_ACT) ? cnt_q : '0;

endmodule

// File: rtl/vga_timgen_pro.sv
// VGA/LCD timing generator top: two axis FSMs plus registered sync/de/strobe outputs.
// Optional line-match interrupt enabled by defining VGA_TIMGEN_LINE_IRQ_EN.
module vga_timgen_pro
    import vga_timgen_pkg::*;
#(
    parameter int unsigned TIM_W = TIM_W_DEF,
    parameter int unsigned ACT_W = ACT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             hpol_i,
    input  logic             vpol_i,
    input  logic [TIM_W-1:0] hsnsize_i,
    input  logic [TIM_W-1:0] hbpsize_i,
    input  logic [TIM_W-1:0] hfpsize_i,
    input  logic [ACT_W-1:0] hvlen_i,
    input  logic [TIM_W-1:0] vsnsize_i,
    input  logic [TIM_W-1:0] vbpsize_i,
    input  logic [TIM_W-1:0] vfpsize_i,
    input  logic [ACT_W-1:0] vvlen_i,
    input  logic [ACT_W-1:0] irq_line_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             hend_o,
    output logic             vend_o,
    output logic             fstart_o,
    output logic [ACT_W-1:0] x_o,
    output logic [ACT_W-1:0] y_o,
    output logic             line_irq_o
);

    axis_cfg_t        h_cfg, v_cfg;
    phase_e           h_ph, v_ph;
    logic [ACT_W-1:0] h_cnt, v_cnt, h_coord, v_coord;
    logic             h_last, v_last;
    logic             run_q, load, hpol_q, vpol_q;

    always_comb begin
        h_cfg      = '0;
        h_cfg.sn   = TIM_W_DEF'(hsnsize_i);
        h_cfg.bp   = TIM_W_DEF'(hbpsize_i);
        h_cfg.fp   = TIM_W_DEF'(hfpsize_i);
        h_cfg.vlen = ACT_W_DEF'(hvlen_i);
        v_cfg      = '0;
        v_cfg.sn   = TIM_W_DEF'(vsnsize_i);
        v_cfg.bp   = TIM_W_DEF'(vbpsize_i);
        v_cfg.fp   = TIM_W_DEF'(vfpsize_i);
        v_cfg.vlen = ACT_W_DEF'(vvlen_i);
    end

    // The axis state leads the outputs by one clock; run_q holds the axes at
    // (0,0) for the first enabled cycle so that pixel is emitted one clock later.
    assign load = !en_i || (run_q && h_last && v_last);

    vga_axis_fsm #(.ACT_W(ACT_W)) u_h_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .adv_i   (run_q),
        .load_i  (load),
        .cfg_i   (h_cfg),
        .ph_o    (h_ph),
        .cnt_o   (h_cnt),
        .last_o  (h_last),
        .coord_o (h_coord)
    );

    vga_axis_fsm #(.ACT_W(ACT_W)) u_v_axis (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .adv_i   (run_q && h_last),
        .load_i  (load),
        .cfg_i   (v_cfg),
        .ph_o    (v_ph),
        .cnt_o   (v_cnt),
        .last_o  (v_last),
        .coord_o (v_coord)
    );

    logic             hsync_q, vsync_q, de_q, hend_q, vend_q, fstart_q;
    logic [ACT_W-1:0] x_q, y_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            hpol_q   <= 1'b0;
            vpol_q   <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            de_q     <= 1'b0;
            hend_q   <= 1'b0;
            vend_q   <= 1'b0;
            fstart_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            run_q <= en_i;
            if (load) begin
                hpol_q <= hpol_i;
                vpol_q <= vpol_i;
            end
            if (en_i && run_q) begin
                hsync_q  <= (h_ph == PH_SYNC) ? hpol_q : !hpol_q;
                vsync_q  <= (v_ph == PH_SYNC) ? vpol_q : !vpol_q;
                de_q     <= (h_ph == PH_ACT) && (v_ph == PH_ACT);
                hend_q   <= h_last;
                vend_q   <= h_last && v_last;
                fstart_q <= (h_ph == PH_SYNC) && (h_cnt == '0) &&
                            (v_ph == PH_SYNC) && (v_cnt == '0);
                x_q      <= h_coord;
                y_q      <= v_coord;
            end else begin
                hsync_q  <= !hpol_q;
                vsync_q  <= !vpol_q;
                de_q     <= 1'b0;
                hend_q   <= 1'b0;
                vend_q   <= 1'b0;
                fstart_q <= 1'b0;
                x_q      <= '0;
                y_q      <= '0;
            end
        end
    end

`ifdef VGA_TIMGEN_LINE_IRQ_EN
    logic irq_q;

    // y never exceeds vvlen, so an out-of-range irq_line_i simply never matches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= en_i && run_q && (h_ph == PH_SYNC) && (h_cnt == '0) &&
                     (v_ph == PH_ACT) && (v_coord == irq_line_i);
        end
    end

    assign line_irq_o = irq_q;
`else
    logic unused_irq_line;

    assign unused_irq_line = ^irq_line_i;
    assign line_irq_o      = 1'b0;
`endif

    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
    assign de_o     = de_q;
    assign hend_o   = hend_q;
    assign vend_o   = vend_q;
    assign fstart_o = fstart_q;
    assign x_o      = x_q;
    assign y_o      = y_q;

endmodule

// File: doc/vga_timgen_pro.md
# vga_timgen_pro

Parametrised VGA/LCD timing generator. It produces horizontal and vertical sync, data-enable, end-of-line and end-of-frame strobes, and active-area pixel coordinates. Timing configuration is shadowed and applied only at frame boundaries, and sync polarity is programmable. It sits between the register block and the pixel FIFO/output stage, and drives the scan-out of every supported display mode.

## Interface
- TIM_W, default 8: width of sync/porch size fields.
- ACT_W, default 12: width of active-length fields and of the x/y coordinates.
- clk_i, in, 1: pixel clock, the only clock.
- rst_i, in, 1: asynchronous, active-high reset.
- en_i, in, 1: timing enable.
- hpol_i / vpol_i, in, 1 each: sync polarity; 1 = active-high pulse, 0 = active-low pulse.
- hsnsize_i / hbpsize_i / hfpsize_i, in, TIM_W each: horizontal sync/back-porch/front-porch length minus 1, in pixel clocks.
- hvlen_i, in, ACT_W: horizontal active length minus 1.
- vsnsize_i / vbpsize_i / vfpsize_i, in, TIM_W each: vertical phase lengths minus 1, in lines.
- vvlen_i, in, ACT_W: vertical active length minus 1.
- irq_line_i, in, ACT_W: active line index for the line interrupt (macro-gated).
- hsync_o / vsync_o, out, 1: sync outputs with polarity applied.
- de_o, out, 1: high when both axes are in the ACTIVE phase.
- hend_o, out, 1: one-cycle pulse on the last clock of each line.
- vend_o, out, 1: one-cycle pulse on the last clock of each frame.
- fstart_o, out, 1: one-cycle pulse on the first clock of each frame.
- x_o / y_o, out, ACT_W each: active pixel/line index; 0 outside the active region.
- line_irq_o, out, 1: line-match pulse (macro-gated).

## Operation
- Each axis runs a 4-phase FSM in the order SYNC → BP → ACTIVE → FP → SYNC. Each phase lasts its field value + 1 units, so no phase is ever zero-length.
- The horizontal axis advances every clock while enabled. The vertical axis advances only on cycles where hend_o is high.
- The phase counter is ACT_W bits. TIM_W fields are zero-extended when compared against it.
- hend_o is high when the horizontal axis is in FP and its counter equals hfpsize. vend_o is high when hend_o is high, the vertical axis is in FP, and its counter equals vfpsize.
- Shadow registers hold all size fields and both polarities.
  - While en_i is low, the shadow registers load every clock (transparent).
  - While en_i is high, they load only in the cycle where vend_o is high, so a new mode takes effect from the next frame with no torn frame.
- en_i low: both FSMs are forced to SYNC with counters at 0. All outputs are held inactive: syncs at their inactive level (the inverse of their polarity bit), de_o/pulses/x/y at 0.
- en_i high: the first enabled cycle is frame pixel (0,0) in SYNC/SYNC. fstart_o pulses and both syncs are asserted.
- Dropping en_i mid-frame aborts the frame on the next clock. Raising it again always restarts at (0,0).
- x_o counts 0..hvlen during horizontal ACTIVE. y_o counts 0..vvlen during vertical ACTIVE and holds for the whole line.
- Reset values: both FSMs in SYNC with counters at 0. hsync_o/vsync_o are at their inactive level for reset-value polarity, which is 1 (active-low default, shadow pol = 0). All other outputs are 0. Shadow size fields reset to 0.

## Timing
- All outputs are registered and change only on the rising edge of clk_i. There is no combinational path from the inputs to the outputs.
- Latency: en_i sampled high at edge N → fstart_o and syncs active after edge N+1.
- Line period = (hsn+1)+(hbp+1)+(hvlen+1)+(hfp+1) clocks. Frame period = the vertical phase sum × the line period.
- Simultaneous shadow load and en_i falling: en_i low wins and the idle state applies.

## Configuration
- Macro VGA_TIMGEN_LINE_IRQ_EN.
- Defined: line_irq_o pulses for one clock on the first clock of the horizontal SYNC phase of the line where the vertical axis is ACTIVE and y equals irq_line_i. irq_line_i is sampled live, not shadowed. There is no pulse if irq_line_i > vvlen.
- Undefined: the comparator is removed and line_irq_o is tied to 0. The port remains.

## Structure
- Package vga_timgen_pkg holds:
  - the phase enum (PH_SYNC, PH_BP, PH_ACT, PH_FP);
  - a packed axis-config struct (sn, bp, fp, vlen) parametrised via TIM_W/ACT_W defaults.
- Sub-module vga_axis_fsm is instantiated twice (horizontal and vertical). It contains the phase FSM, the counter, the shadow registers and the end/coordinate logic.
- The top level handles polarity, de, fstart and the line interrupt.

## Test plan
All scenarios use h = (sn 1, bp 1, vlen 7, fp 1), giving 14 clk/line, and v = (0, 0, 3, 0), giving 7 lines and 98 clk/frame.
- Reset, then en_i=1 → fstart_o after 1 clk. Check:
  - hsync low for 2 clk, pol=0;
  - de_o high 8 clk per line on lines 2–5 only;
  - x_o 0..7;
  - hend_o every 14 clk;
  - vend_o every 98 clk.
- Set hpol/vpol=1 mid-frame → polarity is unchanged until after the next vend_o, then the syncs become active-high. Idle level while disabled = 0.
- Change hvlen to 3 mid-frame → the current frame keeps 14-clk lines. The next frame has 10-clk lines, starting right after vend_o.
- Deassert en_i at pixel 5 of line 3 → the next clock has de_o=0, x/y=0 and syncs inactive. Re-enable → fstart_o, restarting at (0,0).
- With VGA_TIMGEN_LINE_IRQ_EN and irq_line_i=2 → one line_irq_o pulse per frame, at the start of line 4. With irq_line_i=5 → no pulse.
- Assert rst_i asynchronously mid-line → all outputs return to their reset values immediately, without waiting for a clock edge.
